aging_dynamic_priority_arbiter: RTL and testbench

Registered, multi-cycle successor to the combinational linear dynamic-priority arbiter. It picks among N requesters by per-requester dynamic priority, where the lowest value wins. It holds the grant until the owner signals completion. Optional aging promotes requesters that keep losing, so a low-priority requester cannot starve. It sits in front of shared single-owner resources such as a bus port or memory bank, where an owner keeps access for several cycles.

---
 rtl/aging_dynamic_priority_arbiter_if.sv | 23 ++
 rtl/aging_dynamic_priority_arbiter.sv | 101 ++++++++++
 tb/tb_aging_dynamic_priority_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/aging_dynamic_priority_arbiter_if.sv
// Request/grant bundle between requesters and the aging dynamic-priority arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface aging_dynamic_priority_arbiter_if #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
);
  logic [N-1:0]         req;
  logic [N*PW-1:0]      prt;
  logic                 done;
  logic                 gnt_valid;
  logic [$clog2(N)-1:0] gnt_idx;
  logic [N-1:0]         gnt_onehot;

  modport master (
    output req, prt, done,
    input  gnt_valid, gnt_idx, gnt_onehot
  );

  modport slave (
    input  req, prt, done,
    output gnt_valid, gnt_idx, gnt_onehot
  );
endinterface

// File: rtl/aging_dynamic_priority_arbiter.sv
// Registered dynamic-priority arbiter with grant hold/release; lowest effective priority wins,
// ties go to the highest index. Define ARB_AGING_EN to build the per-requester aging counters.
module aging_dynamic_priority_arbiter #(
  parameter int N     = 4,
  parameter int PW    = $clog2(N),
  parameter int AGE_W = 4
) (
  input logic                           clk,
  input logic                           rst,
  aging_dynamic_priority_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int EW = (PW > AGE_W) ? PW : AGE_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic            gnt_valid_reg;
  logic [IW-1:0]   gnt_idx_reg;
  logic [N-1:0]    gnt_onehot_reg;

  logic [EW-1:0]   eff [N];
  logic [IW-1:0]   win_idx;
  logic [EW-1:0]   win_eff;

`ifdef ARB_AGING_EN
  logic [AGE_W-1:0] age_reg [N];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_eff
      logic [EW-1:0] p_ext;
      assign p_ext = EW'(bus.prt[gi*PW +: PW]);
`ifdef ARB_AGING_EN
      logic [EW-1:0] a_ext;
      assign a_ext   = EW'(age_reg[gi]);
      // Aging pulls the effective priority toward 0, clamped there.
      assign eff[gi] = (p_ext > a_ext) ? (p_ext - a_ext) : '0;
`else
      assign eff[gi] = p_ext;
`endif
    end
  endgenerate

  // Ascending scan with <= lets a later equal candidate take over, so ties go high.
  always_comb begin
    win_idx = '0;
    win_eff = '1;
    for (int i = 0; i < N; i++) begin
      if (bus.req[i] && (eff[i] <= win_eff)) begin
        win_idx = IW'(i);
        win_eff = eff[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_valid_reg  <= 1'b0;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
`ifdef ARB_AGING_EN
      for (int i = 0; i < N; i++) age_reg[i] <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_reg      <= BUSY;
            gnt_valid_reg  <= 1'b1;
            gnt_idx_reg    <= win_idx;
            gnt_onehot_reg <= N'(1) << win_idx;
`ifdef ARB_AGING_EN
            for (int i = 0; i < N; i++) begin
              if (!bus.req[i] || (IW'(i) == win_idx))
                age_reg[i] <= '0;
              else if (age_reg[i] != '1)
                age_reg[i] <= age_reg[i] + AGE_W'(1);
            end
`endif
          end
        end
        BUSY: begin
          // Owner either signals completion or drops its request.
          if (bus.done || !bus.req[gnt_idx_reg]) begin
            state_reg      <= IDLE;
            gnt_valid_reg  <= 1'b0;
            gnt_onehot_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt_valid  = gnt_valid_reg;
  assign bus.gnt_idx    = gnt_idx_reg;
  assign bus.gnt_onehot = gnt_onehot_reg;
endmodule

// File: tb/tb_aging_dynamic_priority_arbiter.sv
// Self-checking bench: behavioural arbiter model compared every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_aging_dynamic_priority_arbiter;
  localparam int N     = 4;
  localparam int PW    = 2;
  localparam int AGE_W = 4;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic clk = 1'b0;
  logic rst;

  aging_dynamic_priority_arbiter_if #(.N(N), .PW(PW)) bus ();

  aging_dynamic_priority_arbiter #(.N(N), .PW(PW), .AGE_W(AGE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_ready = 0;
  bit m_busy  = 0;
  int m_idx   = 0;
  int m_age [N];

  function automatic int eff_of(input int i);
    int p;
    p = int'(bus.prt[i*PW +: PW]);
`ifdef ARB_AGING_EN
    p = p - m_age[i];
    if (p < 0) p = 0;
`endif
    return p;
  endfunction

  always @(posedge clk) begin
    int e [N];
    int best;
    int w;
    if (rst) begin
      m_ready = 1;
      m_busy  = 0;
      m_idx   = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else if (m_ready) begin
      if (m_busy) begin
        if (bus.done || !bus.req[m_idx]) m_busy = 0;
      end else if (bus.req != '0) begin
        best = 1 << 30;
        for (int i = 0; i < N; i++) begin
          e[i] = eff_of(i);
          if (bus.req[i] && e[i] < best) best = e[i];
        end
        w = 0;
        for (int i = 0; i < N; i++)
          if (bus.req[i] && e[i] == best) w = i;
        for (int i = 0; i < N; i++) begin
          if (!bus.req[i] || i == w) m_age[i] = 0;
          else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
        end
        m_busy = 1;
        m_idx  = w;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("cyc_valid",  int'(bus.gnt_valid),  int'(m_busy));
      check("cyc_idx",    int'(bus.gnt_idx),    m_idx);
      check("cyc_onehot", int'(bus.gnt_onehot), m_busy ? (1 << m_idx) : 0);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [N*PW-1:0] mk_prt(input int p0, p1, p2, p3);
    logic [N*PW-1:0] v;
    v = {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int v, input int idx, input int oh);
    check({name, "_valid"},  int'(bus.gnt_valid),  v);
    check({name, "_idx"},    int'(bus.gnt_idx),    idx);
    check({name, "_onehot"}, int'(bus.gnt_onehot), oh);
  endtask

  int exp_age_win [4];

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.prt  = mk_prt(3, 1, 1, 2);
    bus.done = 1'b0;

    // Reset held for two cycles with everyone requesting
    step(); chk_out("rst1", 0, 0, 0);
    step(); chk_out("rst2", 0, 0, 0);
    rst = 1'b0;
    // prt {3,1,1,2}: 1 and 2 tie, higher index wins
    step(); chk_out("tie", 1, 2, 4'b0100);

    // Hold: others become more urgent, owner keeps the grant
    bus.prt = mk_prt(0, 0, 1, 0);
    step(); chk_out("hold1", 1, 2, 4'b0100);
    step(); chk_out("hold2", 1, 2, 4'b0100);
    bus.done = 1'b1;
    step(); chk_out("release", 0, 2, 0);
    bus.done = 1'b0;
    step(); chk_out("regrant", 1, 3, 4'b1000);

    // Owner abandons without done
    bus.req = 4'b0111;
    step(); chk_out("abandon", 0, 3, 0);

    // Aging: clean ages via reset, then repeated short grants
    bus.req = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.prt = mk_prt(0, 3, 3, 3);
    bus.req = 4'b0011;
`ifdef ARB_AGING_EN
    exp_age_win = '{0, 0, 0, 1};
`else
    exp_age_win = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("aging_arb%0d", k), int'(bus.gnt_idx), exp_age_win[k]);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
    end

    // Reset mid-grant with done asserted
    step(); check("pre_rst_valid", int'(bus.gnt_valid), 1);
    rst = 1'b1;
    bus.done = 1'b1;
    step(); chk_out("rst_mid", 0, 0, 0);
    rst = 1'b0;
    bus.done = 1'b0;
    step(); chk_out("post_rst", 1, 0, 4'b0001);

    // Randomized traffic; the per-cycle compare does the checking
    for (int c = 0; c < 3000; c++) begin
      if (c < 1500) begin
        bus.req = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        bus.prt = 8'($urandom);
      end else begin
        // Keep requester 0 very urgent so others build up age
        bus.req = 4'($urandom_range(0, 15)) | 4'b0001;
        bus.prt = {6'($urandom), 2'b00};
      end
      bus.done = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
